// File: rtl/pc_gen_pkg.sv
// Shared encodings and default addresses for the PC generator.
// Included by npc_calc and pc_gen via import pc_gen_pkg::*.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_RS     = 3'd3,
        NPC_ERET   = 3'd4
    } npc_op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_npc_calc.sv
// Combinational next-PC target mux (PLUS4/BRANCH/JUMP/RS/ERET).
// Ops 5..7 fall back to PLUS4.
module npc_calc
    import pc_gen_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] i_pc,
    input  logic [2:0]    i_npc_op,
    input  logic [25:0]   i_imm,
    input  logic [AW-3:0] i_rs_hi,
    input  logic [AW-1:0] i_epc,
    output logic [AW-1:0] o_pc_plus4,
    output logic [AW-1:0] o_npc
);

    logic [AW-1:0] w_br_off;

    assign o_pc_plus4 = i_pc + AW'(4);
    assign w_br_off   = {{(AW-18){i_imm[15]}}, i_imm[15:0], 2'b00};

    always_comb begin
        o_npc = o_pc_plus4;
        case (i_npc_op)
            NPC_BRANCH: o_npc = o_pc_plus4 + w_br_off;
            NPC_JUMP:   o_npc = {o_pc_plus4[AW-1:28], i_imm, 2'b00};
            NPC_RS:     o_npc = {i_rs_hi, 2'b00};
            NPC_ERET:   o_npc = i_epc;
            default:    o_npc = o_pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// PC register, EPC, halt/resume FSM and retired counter.
// Optional misaligned-RS trap: define NPC_ALIGN_CHK_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int          AW         = 32,
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int          CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic [2:0]       i_npc_op,
    input  logic [25:0]      i_imm,
    input  logic [AW-1:0]    i_rs,
    input  logic             i_exc_req,
    input  logic             i_halt_req,
    input  logic             i_resume,
    output logic [AW-1:0]    o_pc,
    output logic [AW-1:0]    o_pc_plus4,
    output logic [AW-1:0]    o_epc,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_retired,
    output logic             o_align_exc
);

    localparam logic [AW-1:0] P_RST_PC = RESET_PC[AW-1:0];
    localparam logic [AW-1:0] P_EXC_PC = EXC_VECTOR[AW-1:0];

    state_e           r_state;
    state_e           w_state_nxt;
    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    r_epc;
    logic [CNT_W-1:0] r_retired;
    logic             r_align;

    logic [AW-1:0]    w_pc_nxt;
    logic [AW-1:0]    w_epc_nxt;
    logic [CNT_W-1:0] w_ret_nxt;
    logic             w_align_nxt;
    logic [AW-1:0]    w_npc;
    logic             w_misalign;
    logic             w_align_hit;
    logic             w_take_exc;

    npc_calc #(.AW(AW)) u_npc_calc (
        .i_pc       (r_pc),
        .i_npc_op   (i_npc_op),
        .i_imm      (i_imm),
        .i_rs_hi    (i_rs[AW-1:2]),
        .i_epc      (r_epc),
        .o_pc_plus4 (o_pc_plus4),
        .o_npc      (w_npc)
    );

`ifdef NPC_ALIGN_CHK_EN
    assign w_misalign = (i_npc_op == NPC_RS) && (i_rs[1:0] != 2'b00);
`else
    logic [1:0] w_unused_rs;
    assign w_unused_rs = i_rs[1:0];
    assign w_misalign  = 1'b0;
`endif

    // The trap sits at npc_op priority: halt, halt_req and stall mask it.
    assign w_align_hit = (r_state == ST_RUN) && !i_halt_req
                      && !i_stall && w_misalign;
    assign w_take_exc  = i_exc_req || w_align_hit;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_ret_nxt   = r_retired;
        w_align_nxt = 1'b0;
        if (w_take_exc) begin
            w_state_nxt = ST_RUN;
            w_epc_nxt   = r_pc;
            w_pc_nxt    = P_EXC_PC;
            w_ret_nxt   = r_retired + CNT_W'(1);
            w_align_nxt = w_align_hit;
        end else if (r_state == ST_HALT) begin
            if (i_resume) begin
                w_state_nxt = ST_RUN;
            end
        end else if (i_halt_req) begin
            w_state_nxt = ST_HALT;
        end else if (!i_stall) begin
            w_pc_nxt  = w_npc;
            w_ret_nxt = r_retired + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_RUN;
            r_pc      <= P_RST_PC;
            r_epc     <= '0;
            r_retired <= '0;
            r_align   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_epc     <= w_epc_nxt;
            r_retired <= w_ret_nxt;
            r_align   <= w_align_nxt;
        end
    end

    assign o_pc        = r_pc;
    assign o_epc       = r_epc;
    assign o_halted    = (r_state == ST_HALT);
    assign o_retired   = r_retired;
    assign o_align_exc = r_align;

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen (AW=32, default parameters).
// Expected values follow NPC_ALIGN_CHK_EN when the bench is built with it.
module tb_pc_gen;

    localparam bit ALN =
`ifdef NPC_ALIGN_CHK_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, exc_req, halt_req, resume;
    logic [2:0]  npc_op;
    logic [25:0] imm;
    logic [31:0] rs;
    logic [31:0] pc, pc_plus4, epc, retired;
    logic        halted, align_exc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_stall     (stall),
        .i_npc_op    (npc_op),
        .i_imm       (imm),
        .i_rs        (rs),
        .i_exc_req   (exc_req),
        .i_halt_req  (halt_req),
        .i_resume    (resume),
        .o_pc        (pc),
        .o_pc_plus4  (pc_plus4),
        .o_epc       (epc),
        .o_halted    (halted),
        .o_retired   (retired),
        .o_align_exc (align_exc)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  op;
        logic [25:0] imm;
        logic [31:0] rs;
        logic        exc;
        logic        halt;
        logic        res;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        hlt;
        logic [31:0] ret;
        logic        al;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic [2:0] op,
                       input logic [25:0] im, input logic [31:0] rv,
                       input logic e, input logic h, input logic rsm,
                       input logic [31:0] xpc, input logic [31:0] xepc,
                       input logic xh, input logic [31:0] xret,
                       input logic xal);
        vec_t v;
        v.rst = r; v.stall = s; v.op = op; v.imm = im; v.rs = rv;
        v.exc = e; v.halt = h; v.res = rsm;
        v.pc = xpc; v.epc = xepc; v.hlt = xh; v.ret = xret; v.al = xal;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; stall = v.stall; npc_op = v.op; imm = v.imm;
        rs = v.rs; exc_req = v.exc; halt_req = v.halt; resume = v.res;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d.pc", i), pc, v.pc);
        chk($sformatf("v%0d.pc_plus4", i), pc_plus4, v.pc + 32'd4);
        chk($sformatf("v%0d.epc", i), epc, v.epc);
        chk($sformatf("v%0d.halted", i), {31'd0, halted}, {31'd0, v.hlt});
        chk($sformatf("v%0d.retired", i), retired, v.ret);
        chk($sformatf("v%0d.align", i), {31'd0, align_exc}, {31'd0, v.al});
    endtask

    initial begin
        vec_t hv;
        rst = 1'b1; stall = 1'b0; npc_op = 3'd0; imm = '0; rs = '0;
        exc_req = 1'b0; halt_req = 1'b0; resume = 1'b0;

        //  rst stall op   imm         rs            exc hlt res  pc            epc           h  ret  al
        add(1, 0, 3'd0, 26'h0,      32'h0,         0, 0, 0, 32'h3000,     32'h0,        0, 0,  0);
        add(0, 0, 3'd0, 26'h0,      32'h0,         0, 0, 0, 32'h3004,     32'h0,        0, 1,  0);
        add(0, 0, 3'd0, 26'h0,      32'h0,         0, 0, 0, 32'h3008,     32'h0,        0, 2,  0);
        add(0, 0, 3'd0, 26'h0,      32'h0,         0, 0, 0, 32'h300C,     32'h0,        0, 3,  0);
        add(1, 0, 3'd2, 26'h0,      32'h0,         1, 1, 0, 32'h3000,     32'h0,        0, 0,  0);
        add(0, 0, 3'd1, 26'hFFFE,   32'h0,         0, 0, 0, 32'h2FFC,     32'h0,        0, 1,  0);
        add(0, 0, 3'd2, 26'hC10,    32'h0,         0, 0, 0, 32'h3040,     32'h0,        0, 2,  0);
        add(0, 1, 3'd2, 26'hC04,    32'h0,         0, 0, 0, 32'h3040,     32'h0,        0, 2,  0);
        add(0, 1, 3'd2, 26'hC04,    32'h0,         0, 0, 0, 32'h3040,     32'h0,        0, 2,  0);
        add(0, 0, 3'd2, 26'hC04,    32'h0,         0, 0, 0, 32'h3010,     32'h0,        0, 3,  0);
        add(0, 1, 3'd0, 26'h0,      32'h0,         1, 0, 0, 32'h4180,     32'h3010,     0, 4,  0);
        add(0, 0, 3'd4, 26'h0,      32'h0,         0, 0, 0, 32'h3010,     32'h3010,     0, 5,  0);
        add(0, 0, 3'd2, 26'hC08,    32'h0,         0, 0, 0, 32'h3020,     32'h3010,     0, 6,  0);
        add(0, 0, 3'd0, 26'h0,      32'h0,         0, 1, 0, 32'h3020,     32'h3010,     1, 6,  0);
        for (int k = 0; k < 4; k++)
            add(0, 0, 3'd0, 26'h0,  32'h0,         0, 0, 0, 32'h3020,     32'h3010,     1, 6,  0);
        add(0, 0, 3'd0, 26'h0,      32'h0,         0, 1, 1, 32'h3020,     32'h3010,     0, 6,  0);
        add(0, 0, 3'd0, 26'h0,      32'h0,         0, 0, 0, 32'h3024,     32'h3010,     0, 7,  0);
        add(0, 0, 3'd0, 26'h0,      32'h0,         0, 1, 0, 32'h3024,     32'h3010,     1, 7,  0);
        add(0, 0, 3'd0, 26'h0,      32'h0,         1, 0, 0, 32'h4180,     32'h3024,     0, 8,  0);
        add(0, 0, 3'd4, 26'h0,      32'h0,         1, 0, 0, 32'h4180,     32'h4180,     0, 9,  0);
        add(0, 0, 3'd3, 26'h0,      32'h3000,      0, 0, 0, 32'h3000,     32'h4180,     0, 10, 0);
        add(0, 0, 3'd3, 26'h0,      32'h3006,      0, 0, 0,
            ALN ? 32'h4180 : 32'h3004, ALN ? 32'h3000 : 32'h4180,                     0, 11, ALN);
        add(0, 0, 3'd0, 26'h0,      32'h0,         0, 0, 0,
            ALN ? 32'h4184 : 32'h3008, ALN ? 32'h3000 : 32'h4180,                     0, 12, 0);
        add(0, 1, 3'd3, 26'h0,      32'h3006,      0, 0, 0,
            ALN ? 32'h4184 : 32'h3008, ALN ? 32'h3000 : 32'h4180,                     0, 12, 0);
        add(0, 0, 3'd3, 26'h0,      32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC,
            ALN ? 32'h3000 : 32'h4180,                                                0, 13, 0);
        add(0, 0, 3'd0, 26'h0,      32'h0,         0, 0, 0, 32'h0,
            ALN ? 32'h3000 : 32'h4180,                                                0, 14, 0);
        add(0, 0, 3'd1, 26'h0001,   32'h0,         0, 0, 0, 32'h8,
            ALN ? 32'h3000 : 32'h4180,                                                0, 15, 0);
        add(0, 0, 3'd5, 26'h3FF,    32'h0,         0, 0, 0, 32'hC,
            ALN ? 32'h3000 : 32'h4180,                                                0, 16, 0);
        add(0, 0, 3'd7, 26'h3FF,    32'h0,         0, 0, 0, 32'h10,
            ALN ? 32'h3000 : 32'h4180,                                                0, 17, 0);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check_vec(i, vecs[i]);
        end

        // exc_req beats a simultaneous halt_req and stays in RUN
        hv = vecs[0];
        hv.rst = 0; hv.exc = 1; hv.halt = 1; hv.stall = 1; hv.op = 3'd2;
        apply(hv);
        chk("exc_vs_halt.pc", pc, 32'h4180);
        chk("exc_vs_halt.epc", epc, 32'h10);
        chk("exc_vs_halt.halted", {31'd0, halted}, 32'd0);
        chk("exc_vs_halt.retired", retired, 32'd18);

        // halt with misaligned RS pending: no trap, PC held
        hv.exc = 0; hv.halt = 1; hv.stall = 0; hv.op = 3'd3;
        hv.rs = 32'h5002;
        apply(hv);
        chk("halt_rs.pc", pc, 32'h4180);
        chk("halt_rs.halted", {31'd0, halted}, 32'd1);
        chk("halt_rs.align", {31'd0, align_exc}, 32'd0);
        hv.halt = 0;
        apply(hv);
        chk("halt_rs_hold.pc", pc, 32'h4180);
        chk("halt_rs_hold.retired", retired, 32'd18);

        // reset dominates an exception request
        hv.rst = 1; hv.exc = 1;
        apply(hv);
        chk("rst_vs_exc.pc", pc, 32'h3000);
        chk("rst_vs_exc.epc", epc, 32'h0);
        chk("rst_vs_exc.halted", {31'd0, halted}, 32'd0);
        chk("rst_vs_exc.retired", retired, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
